// File: rtl/calc_seq_core.sv
// calc_seq_core: key-stepped calculator with chunked operand entry, a
// multi-cycle shift-add multiplier and a restoring divider/modulo unit.
module calc_seq_core #(
  parameter int IW     = 9,
  parameter int NCHUNK = 2,
  parameter bit CHAIN  = 1'b0
) (
  input  logic                   CLOCK_50,
  input  logic                   key1,
  input  logic                   key0,
  input  logic [IW-1:0]          SW,
  output logic [IW*NCHUNK-1:0]   disp_val,
  output logic                   err,
  output logic                   busy,
  output logic [2:0]             phase
);
  localparam int W  = IW * NCHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [2:0] {
    S_ENTER_A  = 3'd0,
    S_ENTER_OP = 3'd1,
    S_ENTER_B  = 3'd2,
    S_EXEC     = 3'd3,
    S_SHOW     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic              step;
  logic [CW-1:0]     idx_q, idx_d;
  logic              last_chunk;
  logic [W-1:0]      opa_q, opa_d;
  logic [W-1:0]      opb_q, opb_d;
  logic [2:0]        op_q, op_d;
  logic [W-1:0]      res_q, res_d;
  logic              err_q, err_d;
  logic [W-1:0]      disp_q, disp_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [2*W-1:0]    mc_q, mc_d;
  logic [W-1:0]      sh_q, sh_d;
  logic              iter_op;
  logic              exec_done;
  logic [W:0]        sum_w;
  logic [W:0]        rem_sh;
  logic [W:0]        diff;

  // Write switch chunk idx into an operand; chunk 0 (MS) also clears the rest.
  function automatic logic [W-1:0] put_chunk(input logic [W-1:0] cur,
                                             input logic [CW-1:0] idx,
                                             input logic [IW-1:0] sw);
    logic [W-1:0] v;
    v = (idx == '0) ? '0 : cur;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == CW'(k)) v[W-1-k*IW -: IW] = sw;
    end
    return v;
  endfunction

  // Step pulse: two-flop synchroniser plus a previous-value flop for edge detect.
  always_comb begin
    sync_d = {sync_q[1:0], key0};
  end

  assign step       = sync_q[1] & ~sync_q[2];
  assign last_chunk = (idx_q == CW'(NCHUNK - 1));
  assign iter_op    = (op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_MOD);
  assign exec_done  = (state_q == S_EXEC) && (!iter_op || (cnt_q == NW'(W)));
  assign sum_w      = {1'b0, opa_q} + {1'b0, opb_q};
  // Restoring divider: partial remainder lives in acc_q[W-1:0], dividend/quotient in sh_q.
  assign rem_sh     = {acc_q[W-1:0], sh_q[W-1]};
  assign diff       = rem_sh - {1'b0, opb_q};

  // State and synchroniser registers; key1 low aborts everything immediately.
  always_ff @(posedge CLOCK_50 or negedge key1) begin
    if (!key1) begin
      state_q <= S_ENTER_A;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
    end
  end

  // Next-state: steps advance entry states, EXEC ends on its own, steps in EXEC are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ENTER_A:  if (step && last_chunk) state_d = S_ENTER_OP;
      S_ENTER_OP: if (step) state_d = S_ENTER_B;
      S_ENTER_B:  if (step && last_chunk) state_d = S_EXEC;
      S_EXEC:     if (exec_done) state_d = S_SHOW;
      S_SHOW:     if (step) state_d = CHAIN ? S_ENTER_OP : S_ENTER_A;
      default:    state_d = S_ENTER_A;
    endcase
  end

  // Outputs are straight from registered state, no combinational paths from inputs.
  always_comb begin
    phase    = state_q;
    busy     = (state_q == S_EXEC);
    disp_val = disp_q;
    err      = err_q;
  end

  // Datapath registers; cleared by reset so an aborted operation leaves nothing behind.
  always_ff @(posedge CLOCK_50 or negedge key1) begin
    if (!key1) begin
      idx_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      op_q   <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      disp_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      mc_q   <= '0;
      sh_q   <= '0;
    end else begin
      idx_q  <= idx_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      op_q   <= op_d;
      res_q  <= res_d;
      err_q  <= err_d;
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      mc_q   <= mc_d;
      sh_q   <= sh_d;
    end
  end

  // Datapath next values: operand entry, iterative mul/div, result capture.
  always_comb begin
    idx_d  = idx_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    op_d   = op_q;
    res_d  = res_q;
    err_d  = err_q;
    disp_d = disp_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    mc_d   = mc_q;
    sh_d   = sh_q;
    case (state_q)
      S_ENTER_A: begin
        if (step) begin
          opa_d  = put_chunk(opa_q, idx_q, SW);
          disp_d = opa_d;
          idx_d  = last_chunk ? '0 : idx_q + 1'b1;
        end
      end
      S_ENTER_OP: begin
        if (step) begin
          op_d   = SW[2:0];
          disp_d = {{(W-3){1'b0}}, SW[2:0]};
        end
      end
      S_ENTER_B: begin
        if (step) begin
          opb_d  = put_chunk(opb_q, idx_q, SW);
          disp_d = opb_d;
          idx_d  = last_chunk ? '0 : idx_q + 1'b1;
          if (last_chunk) begin
            // Preload the iterative unit: multiplier shifts B, divider shifts A.
            cnt_d = '0;
            acc_d = '0;
            mc_d  = {{W{1'b0}}, opa_q};
            sh_d  = (op_q == OP_MUL) ? opb_d : opa_q;
          end
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            res_d = sum_w[W-1:0];
            err_d = sum_w[W];
          end
          OP_SUB: begin
            res_d = opa_q - opb_q;
            err_d = (opa_q < opb_q);
          end
          OP_MUL, OP_DIV, OP_MOD: begin
            if (cnt_q != NW'(W)) begin
              cnt_d = cnt_q + 1'b1;
              if (op_q == OP_MUL) begin
                if (sh_q[0]) acc_d = acc_q + mc_q;
                mc_d = mc_q << 1;
                sh_d = sh_q >> 1;
              end else begin
                // A negative trial difference means restore (keep the shifted remainder).
                sh_d  = {sh_q[W-2:0], ~diff[W]};
                acc_d = {{W{1'b0}}, (diff[W] ? rem_sh[W-1:0] : diff[W-1:0])};
              end
            end else begin
              // Finalise cycle; divide by zero falls out naturally as all-ones / A.
              if (op_q == OP_MUL) begin
                res_d = acc_q[W-1:0];
                err_d = |acc_q[2*W-1:W];
              end else if (op_q == OP_DIV) begin
                res_d = sh_q;
                err_d = (opb_q == '0);
              end else begin
                res_d = acc_q[W-1:0];
                err_d = (opb_q == '0);
              end
            end
          end
          default: begin
            res_d = '1;
            err_d = 1'b1;
          end
        endcase
        if (exec_done) disp_d = res_d;
      end
      S_SHOW: begin
        if (step) begin
          err_d = 1'b0;
          idx_d = '0;
          if (CHAIN) begin
            opa_d  = res_q;
            disp_d = res_q;
          end else begin
            disp_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_seq_core.sv
// Bench for calc_seq_core: directed scenarios plus randomized calculations
// compared against a plain-arithmetic reference of the calculator.
module tb_calc_seq_core;
  localparam int IW     = 9;
  localparam int NCHUNK = 2;
  localparam int W      = IW * NCHUNK;
  localparam longint unsigned WMASK = (64'd1 << W) - 1;

  logic          clk = 1'b0;
  logic          key1, key0, key0c;
  logic [IW-1:0] SW;
  logic [W-1:0]  disp0, disp1;
  logic          err0, err1, busy0, busy1;
  logic [2:0]    ph0, ph1;

  bit            sel;
  logic [W-1:0]  cur_disp;
  logic          cur_err, cur_busy;
  logic [2:0]    cur_phase;

  int            n_total = 0;
  int            n_bad   = 0;
  int            busy_cnt;
  logic [W-1:0]  disp_at2, disp_at3;

  calc_seq_core #(.IW(IW), .NCHUNK(NCHUNK), .CHAIN(1'b0)) dut (
    .CLOCK_50(clk), .key1(key1), .key0(key0), .SW(SW),
    .disp_val(disp0), .err(err0), .busy(busy0), .phase(ph0));

  calc_seq_core #(.IW(IW), .NCHUNK(NCHUNK), .CHAIN(1'b1)) dut_c (
    .CLOCK_50(clk), .key1(key1), .key0(key0c), .SW(SW),
    .disp_val(disp1), .err(err1), .busy(busy1), .phase(ph1));

  assign cur_disp  = sel ? disp1 : disp0;
  assign cur_err   = sel ? err1  : err0;
  assign cur_busy  = sel ? busy1 : busy0;
  assign cur_phase = sel ? ph1   : ph0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Calculator semantics straight from the operator table.
  function automatic void ref_calc(input int op, input longint unsigned a, input longint unsigned b,
                                   output longint unsigned r, output bit e);
    longint unsigned t;
    case (op)
      0: begin t = a + b; r = t & WMASK; e = (t > WMASK); end
      1: begin r = (a - b) & WMASK; e = (a < b); end
      2: begin t = a * b; r = t & WMASK; e = (t > WMASK); end
      3: begin if (b == 0) begin r = WMASK; e = 1; end else begin r = a / b; e = 0; end end
      4: begin if (b == 0) begin r = a; e = 1; end else begin r = a % b; e = 0; end end
      default: begin r = WMASK; e = 1; end
    endcase
  endfunction

  // One key0 press on the selected instance; records display 2 and 3 edges after the rise.
  task automatic press(input logic [IW-1:0] sw);
    @(posedge clk); #1;
    SW = sw;
    if (sel) key0c = 1'b1; else key0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 disp_at2 = cur_disp;
    @(posedge clk); #1;
    disp_at3 = cur_disp;
    busy_cnt = 0;
    while (cur_busy === 1'b1 && busy_cnt < 200) begin
      busy_cnt++;
      @(posedge clk); #1;
    end
    key0  = 1'b0;
    key0c = 1'b0;
    SW    = IW'($urandom);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic enter_a(input longint unsigned a);
    int sh;
    for (int k = 0; k < NCHUNK; k++) begin
      sh = W - (k + 1) * IW;
      press(IW'(a >> sh));
      check_eq("a_disp", cur_disp, (a >> sh) << sh);
      check_eq("a_phase", cur_phase, (k == NCHUNK - 1) ? 1 : 0);
    end
  endtask

  task automatic enter_op_b(input int op, input longint unsigned a, input longint unsigned b);
    logic [IW-1:0]   s;
    longint unsigned r;
    bit              e;
    int              sh;
    s = IW'($urandom);
    s[2:0] = 3'(op);
    press(s);
    check_eq("op_disp", cur_disp, op);
    check_eq("op_phase", cur_phase, 2);
    check_eq("op_err", cur_err, 0);
    ref_calc(op, a, b, r, e);
    for (int k = 0; k < NCHUNK; k++) begin
      sh = W - (k + 1) * IW;
      press(IW'(b >> sh));
      if (k < NCHUNK - 1) begin
        check_eq("b_disp", cur_disp, (b >> sh) << sh);
        check_eq("b_phase", cur_phase, 2);
      end else begin
        check_eq("busy_len", busy_cnt, (op >= 2 && op <= 4) ? W + 1 : 1);
        check_eq("show_phase", cur_phase, 4);
        check_eq("result", cur_disp, r);
        check_eq("err", cur_err, e);
      end
    end
  endtask

  task automatic run_calc(input longint unsigned a, input int op, input longint unsigned b);
    sel = 0;
    enter_a(a);
    enter_op_b(op, a, b);
    press(IW'($urandom));
    check_eq("leave_phase", cur_phase, 0);
    check_eq("leave_disp", cur_disp, 0);
    check_eq("leave_err", cur_err, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned a, b;
    int              op, n;
    sel   = 0;
    key1  = 1'b0;
    key0  = 1'b0;
    key0c = 1'b0;
    SW    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_phase", ph0, 0);
    check_eq("rst_disp", disp0, 0);
    check_eq("rst_err", err0, 0);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_phase_c", ph1, 0);
    key1 = 1'b1;
    repeat (2) @(posedge clk);

    // Basic add, plus step-to-state latency on leaving SHOW.
    run_calc('h00200, 0, 'h00005);
    check_eq("lat_edge2", disp_at2, 'h205);
    check_eq("lat_edge3", disp_at3, 0);

    // Boundary arithmetic.
    run_calc('h3FFFF, 0, 1);
    run_calc(5, 1, 9);
    run_calc(300, 2, 700);
    run_calc('h20000, 2, 2);
    run_calc(1000, 3, 7);
    run_calc(1000, 4, 7);
    run_calc(1234, 3, 0);
    run_calc(1234, 4, 0);
    run_calc(77, 6, 3);

    // Steps during EXEC are dropped.
    sel = 0;
    enter_a(300);
    press(IW'(2));
    press(IW'(700 >> IW));
    @(posedge clk); #1;
    SW = IW'(700); key0 = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_eq("exec_busy", busy0, 1);
    check_eq("exec_phase", ph0, 3);
    key0 = 1'b0;
    repeat (2) @(posedge clk); #1;
    key0 = 1'b1;
    repeat (5) @(posedge clk); #1;
    check_eq("exec_hold", ph0, 3);
    n = 0;
    while (busy0 === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
    check_eq("drop_phase", ph0, 4);
    check_eq("drop_result", disp0, 210000);
    key0 = 1'b0;
    repeat (4) @(posedge clk); #1;
    check_eq("no_queue", ph0, 4);
    press(IW'(0));
    check_eq("drop_leave", ph0, 0);

    // Reset in the middle of a multiply.
    enter_a(12345);
    press(IW'(2));
    press(IW'(9 >> IW));
    @(posedge clk); #1;
    SW = IW'(9); key0 = 1'b1;
    repeat (8) @(posedge clk); #1;
    check_eq("mid_busy", busy0, 1);
    #2 key1 = 1'b0;
    #1;
    check_eq("arst_phase", ph0, 0);
    check_eq("arst_busy", busy0, 0);
    check_eq("arst_disp", disp0, 0);
    check_eq("arst_err", err0, 0);
    key0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    key1 = 1'b1;
    repeat (2) @(posedge clk);
    run_calc(7, 0, 9);

    // Chaining instance: result feeds operand A.
    sel = 1;
    enter_a(5);
    enter_op_b(0, 5, 3);
    press(IW'($urandom));
    check_eq("chain_phase", ph1, 1);
    check_eq("chain_disp", disp1, 8);
    check_eq("chain_err", err1, 0);
    enter_op_b(2, 8, 4);
    press(IW'($urandom));
    check_eq("chain2_phase", ph1, 1);
    check_eq("chain2_disp", disp1, 32);
    sel = 0;

    // Randomized calculations.
    for (int t = 0; t < 40; t++) begin
      a  = longint'($urandom) & WMASK;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 2000);
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2, 3: b = $urandom_range(1, 20);
        default: b = longint'($urandom) & WMASK;
      endcase
      op = $urandom_range(0, 7);
      run_calc(a, op, b);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
